jedro_1_trap_ctrl: RTL and testbench

//  Trap sequencer between core pipeline and CSR file. Arbitrates synchronous exceptions, MRET and

---
 rtl/jedro_1_trap_ctrl.sv | 103 ++++++++++
 tb/tb_jedro_1_trap_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/jedro_1_trap_ctrl.sv
// jedro_1_trap_ctrl: trap sequencer arbitrating exceptions, MRET and machine interrupts
module jedro_1_trap_ctrl #(
  parameter int DATA_WIDTH       = 32,
  parameter int FLUSH_MAX_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  exc_valid_i,
  input  logic [3:0]            exc_cause_i,
  input  logic [DATA_WIDTH-1:0] exc_pc_i,
  input  logic [DATA_WIDTH-1:0] exc_tval_i,
  input  logic                  mret_i,
  input  logic [DATA_WIDTH-1:0] next_pc_i,
  input  logic                  irq_ext_i,
  input  logic                  irq_sw_i,
  input  logic                  irq_timer_i,
  input  logic                  mstatus_mie_i,
  input  logic                  mstatus_mpie_i,
  input  logic [DATA_WIDTH-1:0] mie_i,
  input  logic [DATA_WIDTH-1:0] mtvec_i,
  input  logic [DATA_WIDTH-1:0] mepc_i,
  input  logic                  lsu_idle_i,
  output logic                  exc_ack_o,
  output logic                  busy_o,
  output logic                  flush_o,
  output logic                  csr_trap_we_o,
  output logic [DATA_WIDTH-1:0] csr_mepc_o,
  output logic [DATA_WIDTH-1:0] csr_mcause_o,
  output logic [DATA_WIDTH-1:0] csr_mtval_o,
  output logic                  csr_mstatus_we_o,
  output logic                  csr_mie_o,
  output logic                  csr_mpie_o,
  output logic                  jmp_o,
  output logic [DATA_WIDTH-1:0] jmp_addr_o
);
  localparam int CW = $clog2(FLUSH_MAX_CYCLES);
  typedef enum logic [2:0] {IDLE, FLUSH, COMMIT, JUMP, MRET} state_t;
  state_t                state;
  logic [DATA_WIDTH-1:0] cause_q, pc_q, tval_q, vec_off;
  logic [CW-1:0]         cnt;
  logic                  mei, msi, mti, irq_pend, unused_bits;
  logic [3:0]            irq_code;
  assign mei         = irq_ext_i & mie_i[11];
  assign msi         = irq_sw_i & mie_i[3];
  assign mti         = irq_timer_i & mie_i[7];
  assign irq_pend    = mstatus_mie_i & (mei | msi | mti);
  assign irq_code    = mei ? 4'd11 : msi ? 4'd3 : 4'd7;
  assign unused_bits = ^{mie_i[DATA_WIDTH-1:12], mie_i[10:8], mie_i[6:4], mie_i[2:0],
                         cause_q[DATA_WIDTH-2:4]};
  // sequencer: arbitrate in IDLE, then flush, commit CSRs and redirect fetch
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cause_q <= '0;
      pc_q    <= '0;
      tval_q  <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (exc_valid_i) begin
            cause_q <= {{(DATA_WIDTH-4){1'b0}}, exc_cause_i};
            pc_q    <= exc_pc_i;
            tval_q  <= exc_tval_i;
            state   <= FLUSH;
          end else if (mret_i) begin
            state <= MRET;
          end else if (irq_pend) begin
            cause_q <= {1'b1, {(DATA_WIDTH-5){1'b0}}, irq_code};
            pc_q    <= next_pc_i;
            tval_q  <= '0;
            state   <= FLUSH;
          end
        end
        FLUSH: begin
          cnt <= cnt + 1'b1;
          if (lsu_idle_i || cnt == CW'(FLUSH_MAX_CYCLES-1)) state <= COMMIT;
        end
        COMMIT:  state <= JUMP;
        default: state <= IDLE;
      endcase
    end
  end
  // outputs are pure decodes of the state; data buses stay zero while their strobe is low
  always_comb begin
    exc_ack_o        = (state == IDLE) & (exc_valid_i | mret_i);
    busy_o           = state != IDLE;
    flush_o          = state == FLUSH;
    csr_trap_we_o    = state == COMMIT;
    csr_mepc_o       = csr_trap_we_o ? pc_q : '0;
    csr_mcause_o     = csr_trap_we_o ? cause_q : '0;
    csr_mtval_o      = csr_trap_we_o ? tval_q : '0;
    csr_mstatus_we_o = (state == COMMIT) | (state == MRET);
    csr_mie_o        = (state == MRET) & mstatus_mpie_i;
    csr_mpie_o       = (state == COMMIT) ? mstatus_mie_i : (state == MRET);
    jmp_o            = (state == JUMP) | (state == MRET);
    vec_off          = (mtvec_i[1:0] == 2'b01 && cause_q[DATA_WIDTH-1]) ?
                       {{(DATA_WIDTH-6){1'b0}}, cause_q[3:0], 2'b00} : '0;
    jmp_addr_o       = (state == JUMP) ? {mtvec_i[DATA_WIDTH-1:2], 2'b00} + vec_off :
                       (state == MRET) ? mepc_i : '0;
  end
endmodule

// File: tb/tb_jedro_1_trap_ctrl.sv
// tb_jedro_1_trap_ctrl: table-driven and scoreboard bench for the trap sequencer
module tb_jedro_1_trap_ctrl;
  logic        clk_i = 0, rst_i = 1;
  logic        exc_valid_i = 0, mret_i = 0, irq_ext_i = 0, irq_sw_i = 0, irq_timer_i = 0;
  logic [3:0]  exc_cause_i = 0;
  logic [31:0] exc_pc_i = 0, exc_tval_i = 0, next_pc_i = 0, mie_i = 0, mtvec_i = 0, mepc_i = 0;
  logic        mstatus_mie_i = 0, mstatus_mpie_i = 0, lsu_idle_i = 1;
  logic        exc_ack_o, busy_o, flush_o, csr_trap_we_o, csr_mstatus_we_o, csr_mie_o, csr_mpie_o, jmp_o;
  logic [31:0] csr_mepc_o, csr_mcause_o, csr_mtval_o, jmp_addr_o;

  jedro_1_trap_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i),
    .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i), .mret_i(mret_i), .next_pc_i(next_pc_i),
    .irq_ext_i(irq_ext_i), .irq_sw_i(irq_sw_i), .irq_timer_i(irq_timer_i),
    .mstatus_mie_i(mstatus_mie_i), .mstatus_mpie_i(mstatus_mpie_i), .mie_i(mie_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i), .lsu_idle_i(lsu_idle_i), .exc_ack_o(exc_ack_o),
    .busy_o(busy_o), .flush_o(flush_o), .csr_trap_we_o(csr_trap_we_o), .csr_mepc_o(csr_mepc_o),
    .csr_mcause_o(csr_mcause_o), .csr_mtval_o(csr_mtval_o), .csr_mstatus_we_o(csr_mstatus_we_o),
    .csr_mie_o(csr_mie_o), .csr_mpie_o(csr_mpie_o), .jmp_o(jmp_o), .jmp_addr_o(jmp_addr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  cause;
    logic [31:0] pc, tval, next_pc;
    logic [2:0]  irq;
    logic [31:0] mie;
    logic        st_mie, st_mpie;
    logic [31:0] mtvec, mepc;
    logic        ack, ev, trap;
    logic [31:0] x_mcause, x_mepc, x_mtval, x_jmp;
    logic        x_mie, x_mpie;
  } vec_t;

  typedef struct packed {
    logic        trap;
    logic [31:0] mcause, mepc, mtval, jmp;
    logic        mie, mpie;
  } ev_t;

  ev_t q[$];
  int  n_pass = 0, n_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // scoreboard: every trap write and redirect must match the oldest outstanding expectation
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (csr_trap_we_o) begin
        if (q.size() == 0 || !q[0].trap) chk("unexpected_trap_we", 1, 0);
        else begin
          chk("mcause", csr_mcause_o, q[0].mcause);
          chk("mepc", csr_mepc_o, q[0].mepc);
          chk("mtval", csr_mtval_o, q[0].mtval);
          chk("trap_mstatus_we", {31'b0, csr_mstatus_we_o}, 1);
          chk("trap_csr_mie", {31'b0, csr_mie_o}, {31'b0, q[0].mie});
          chk("trap_csr_mpie", {31'b0, csr_mpie_o}, {31'b0, q[0].mpie});
        end
      end else begin
        chk("trap_bus_idle", csr_mcause_o | csr_mepc_o | csr_mtval_o, 0);
      end
      if (jmp_o) begin
        if (q.size() == 0) chk("unexpected_jmp", 1, 0);
        else begin
          chk("jmp_addr", jmp_addr_o, q[0].jmp);
          if (!q[0].trap) begin
            chk("mret_no_trap_we", {31'b0, csr_trap_we_o}, 0);
            chk("mret_mstatus_we", {31'b0, csr_mstatus_we_o}, 1);
            chk("mret_csr_mie", {31'b0, csr_mie_o}, {31'b0, q[0].mie});
            chk("mret_csr_mpie", {31'b0, csr_mpie_o}, {31'b0, q[0].mpie});
          end
          void'(q.pop_front());
        end
      end else begin
        chk("jmp_addr_idle", jmp_addr_o, 0);
      end
    end
  end

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk_i);
      done = !busy_o;
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  task automatic apply(input vec_t v);
    @(posedge clk_i); #1;
    exc_valid_i = (v.kind == 0); mret_i = (v.kind == 1);
    exc_cause_i = v.cause; exc_pc_i = v.pc; exc_tval_i = v.tval; next_pc_i = v.next_pc;
    {irq_ext_i, irq_sw_i, irq_timer_i} = v.irq;
    mie_i = v.mie; mstatus_mie_i = v.st_mie; mstatus_mpie_i = v.st_mpie;
    mtvec_i = v.mtvec; mepc_i = v.mepc;
    if (v.ev) q.push_back('{v.trap, v.x_mcause, v.x_mepc, v.x_mtval, v.x_jmp, v.x_mie, v.x_mpie});
    @(negedge clk_i);
    chk("ack", {31'b0, exc_ack_o}, {31'b0, v.ack});
    @(posedge clk_i); #1;
    exc_valid_i = 0; mret_i = 0; {irq_ext_i, irq_sw_i, irq_timer_i} = 3'b000;
    wait_idle();
  endtask

  vec_t vt[12];
  int lat, nf, ct;

  initial begin
    // kind 0=exc 1=mret 2=irq; irq bits {ext,sw,timer}
    vt[0]  = '{0, 2, 32'h8000_0010, 0, 0, 0, 0, 1, 0, 32'h0040_0000, 0,
               1, 1, 1, 2, 32'h8000_0010, 0, 32'h0040_0000, 0, 1};
    vt[1]  = '{2, 0, 0, 0, 32'h8000_0200, 3'b100, 32'h800, 1, 0, 32'h0040_0001, 0,
               0, 1, 1, 32'h8000_000B, 32'h8000_0200, 0, 32'h0040_002C, 0, 1};
    vt[2]  = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h8000_0104,
               1, 1, 0, 0, 0, 0, 32'h8000_0104, 1, 1};
    vt[3]  = '{2, 0, 0, 0, 32'h0000_0444, 3'b010, 32'h008, 1, 0, 32'h0000_1001, 0,
               0, 1, 1, 32'h8000_0003, 32'h0000_0444, 0, 32'h0000_100C, 0, 1};
    vt[4]  = '{2, 0, 0, 0, 32'h0000_0888, 3'b001, 32'h080, 1, 1, 32'h0000_2001, 0,
               0, 1, 1, 32'h8000_0007, 32'h0000_0888, 0, 32'h0000_201C, 0, 1};
    vt[5]  = '{0, 5, 32'h8000_0400, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 32'h0000_2001, 0,
               1, 1, 1, 5, 32'h8000_0400, 32'hDEAD_BEEF, 32'h0000_2000, 0, 0};
    vt[6]  = '{2, 0, 0, 0, 32'h0000_0010, 3'b111, 32'h888, 1, 0, 32'h0000_3001, 0,
               0, 1, 1, 32'h8000_000B, 32'h0000_0010, 0, 32'h0000_302C, 0, 1};
    vt[7]  = '{2, 0, 0, 0, 32'h0000_0020, 3'b011, 32'h888, 1, 0, 32'h0000_3001, 0,
               0, 1, 1, 32'h8000_0003, 32'h0000_0020, 0, 32'h0000_300C, 0, 1};
    vt[8]  = '{2, 0, 0, 0, 32'h0000_0030, 3'b111, 32'h888, 0, 1, 32'h0000_3001, 0,
               0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[9]  = '{2, 0, 0, 0, 32'h0000_0040, 3'b001, 32'h800, 1, 0, 32'h0000_3001, 0,
               0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[10] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h1234_5678,
               1, 1, 0, 0, 0, 0, 32'h1234_5678, 0, 1};
    vt[11] = '{0, 11, 32'h0000_0100, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFD, 0,
               1, 1, 1, 11, 32'h0000_0100, 0, 32'hFFFF_FFFC, 0, 1};
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_outputs", {24'b0, exc_ack_o, busy_o, flush_o, csr_trap_we_o, csr_mstatus_we_o,
        csr_mie_o, csr_mpie_o, jmp_o}, 0);
    chk("rst_buses", csr_mepc_o | csr_mcause_o | csr_mtval_o | jmp_addr_o, 0);
    @(posedge clk_i); #1 rst_i = 0;
    foreach (vt[i]) apply(vt[i]);

    // simultaneous ECALL + MRET + timer: exception first, timer once back in IDLE
    @(posedge clk_i); #1;
    exc_valid_i = 1; exc_cause_i = 11; exc_pc_i = 32'h8000_0500; exc_tval_i = 0; mret_i = 1;
    irq_timer_i = 1; mie_i = 32'h080; mstatus_mie_i = 1; mstatus_mpie_i = 0;
    next_pc_i = 32'h8000_0504; mtvec_i = 32'h0040_0001;
    q.push_back('{1, 32'd11, 32'h8000_0500, 32'h0, 32'h0040_0000, 1'b0, 1'b1});
    q.push_back('{1, 32'h8000_0007, 32'h8000_0504, 32'h0, 32'h0040_001C, 1'b0, 1'b1});
    @(negedge clk_i); chk("simul_ack", {31'b0, exc_ack_o}, 1);
    @(posedge clk_i); #1 exc_valid_i = 0; mret_i = 0;
    wait_idle();
    chk("simul_ack_irq", {31'b0, exc_ack_o}, 0);
    @(posedge clk_i); #1 irq_timer_i = 0;
    wait_idle();

    // accept-to-redirect latency with the LSU already idle
    @(posedge clk_i); #1;
    exc_valid_i = 1; exc_cause_i = 2; exc_pc_i = 32'h8000_0010; exc_tval_i = 0;
    mtvec_i = 32'h0040_0000; mstatus_mie_i = 1; lsu_idle_i = 1;
    q.push_back('{1, 32'd2, 32'h8000_0010, 32'h0, 32'h0040_0000, 1'b0, 1'b1});
    @(negedge clk_i); chk("lat_ack", {31'b0, exc_ack_o}, 1);
    @(posedge clk_i); #1 exc_valid_i = 0;
    lat = 0; nf = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk_i);
      if (flush_o) nf++;
      if (jmp_o && lat == 0) lat = i;
    end
    chk("latency", lat, 3);
    chk("flush_cycles_idle", nf, 1);

    // LSU never idles: flush is forced to end after 16 cycles
    @(posedge clk_i); #1;
    exc_valid_i = 1; exc_cause_i = 4; exc_pc_i = 32'h8000_0600; exc_tval_i = 32'h0000_0003;
    lsu_idle_i = 0;
    q.push_back('{1, 32'd4, 32'h8000_0600, 32'h3, 32'h0040_0000, 1'b0, 1'b1});
    @(negedge clk_i);
    @(posedge clk_i); #1 exc_valid_i = 0;
    nf = 0; ct = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk_i);
      if (flush_o) nf++;
      if (csr_trap_we_o && ct == 0) ct = i;
    end
    chk("flush_cycles_forced", nf, 16);
    chk("commit_cycle", ct, 17);

    // MIE clear: pending lines must be ignored
    irq_ext_i = 1; irq_sw_i = 1; irq_timer_i = 1; mie_i = 32'h888; mstatus_mie_i = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("mie0_not_taken", {31'b0, busy_o}, 0);
    end
    @(posedge clk_i); #1 {irq_ext_i, irq_sw_i, irq_timer_i} = 3'b000; mstatus_mie_i = 1;

    // reset mid-flush aborts the trap without any write or redirect
    @(posedge clk_i); #1;
    exc_valid_i = 1; exc_cause_i = 6; exc_pc_i = 32'h8000_0700;
    @(posedge clk_i); #1 exc_valid_i = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1;
    @(negedge clk_i); chk("pre_rst_flush", {31'b0, flush_o}, 1);
    @(posedge clk_i); #1 rst_i = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      chk("rst_abort", {29'b0, busy_o, csr_trap_we_o, jmp_o}, 0);
    end
    lsu_idle_i = 1;
    apply(vt[0]);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
